// File: rtl/note_chart_if.sv
// note_chart_if: lane-side bus of the chart sequencer (loader, judge and renderer signals).
// Rev 1.0
`default_nettype none

interface note_chart_if #(
  parameter int DEPTH  = 256,
  parameter int TIME_W = 14,
  parameter int TYPE_W = 2,
  parameter int WIN    = 4
) ();
  localparam int AW     = $clog2(DEPTH);
  localparam int WORD_W = TYPE_W + TIME_W;

  logic                  frame_tick;
  logic                  start;
  logic                  pause;
  logic [AW:0]           chart_len;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [WORD_W-1:0]     wr_data;
  logic                  hit;

  logic [TIME_W-1:0]     game_time;
  logic [AW:0]           head_addr;
  logic [WIN*WORD_W-1:0] win_data;
  logic [WIN-1:0]        win_valid;
  logic                  in_window;
  logic                  hit_ok;
  logic                  miss;
  logic [TYPE_W-1:0]     ret_type;
  logic                  busy;
  logic                  done;

  modport master (
    output frame_tick, start, pause, chart_len, wr_en, wr_addr, wr_data, hit,
    input  game_time, head_addr, win_data, win_valid, in_window,
           hit_ok, miss, ret_type, busy, done
  );

  modport slave (
    input  frame_tick, start, pause, chart_len, wr_en, wr_addr, wr_data, hit,
    output game_time, head_addr, win_data, win_valid, in_window,
           hit_ok, miss, ret_type, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/note_chart_window.sv
// note_chart_window: one-lane chart sequencer with game clock, lookahead window and hit/miss retire.
// Rev 1.0
`default_nettype none

module note_chart_window #(
  parameter int DEPTH   = 256,
  parameter int TIME_W  = 14,
  parameter int TYPE_W  = 2,
  parameter int WIN     = 4,
  parameter int HIT_WIN = 6
) (
  input  logic        Clk,
  input  logic        Reset_n,
  note_chart_if.slave bus
);
  localparam int AW     = $clog2(DEPTH);
  localparam int WORD_W = TYPE_W + TIME_W;
  localparam int CW     = TIME_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW:0]       LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [TIME_W-1:0] TIME_MAX  = '1;
  localparam logic [CW-1:0]     HIT_WIN_C = CW'(HIT_WIN);

  logic [1:0]        state_q, state_d;
  logic [AW:0]       len_q, len_d;
  logic [AW:0]       head_q, head_d;
  logic [TIME_W-1:0] game_time_q, game_time_d;
  logic              hit_ok_q, hit_ok_d;
  logic              miss_q, miss_d;
  logic [TYPE_W-1:0] ret_type_q, ret_type_d;

  logic [WORD_W-1:0] chart_q [DEPTH];
  logic              chart_we;

  logic [WIN*WORD_W-1:0] win_data;
  logic [WIN-1:0]        win_valid;
  logic [WORD_W-1:0]     head_word;
  logic [TIME_W-1:0]     head_time;
  logic [TYPE_W-1:0]     head_type;
  logic [CW-1:0]         gt_ext, ht_ext;
  logic                  in_window, late;
  logic [AW:0]           start_len;
  logic [TIME_W-1:0]     game_time_inc;
  logic                  busy, done;

  // Window index is one bit wider than head so slots beyond DEPTH never alias low entries.
  generate
    for (genvar k = 0; k < WIN; k++) begin : g_win
      logic [AW+1:0] idx;
      assign idx                         = {1'b0, head_q} + (AW+2)'(k);
      assign win_valid[k]                = idx < {1'b0, len_q};
      assign win_data[k*WORD_W +: WORD_W] = win_valid[k] ? chart_q[idx[AW-1:0]] : '0;
    end
  endgenerate

  assign head_word = win_data[WORD_W-1:0];
  assign head_time = head_word[TIME_W-1:0];
  assign head_type = head_word[WORD_W-1:TIME_W];

  assign gt_ext    = {1'b0, game_time_q};
  assign ht_ext    = {1'b0, head_time};
  assign in_window = win_valid[0] && (gt_ext + HIT_WIN_C >= ht_ext)
                                  && (ht_ext + HIT_WIN_C >= gt_ext);
  assign late      = win_valid[0] && (gt_ext > ht_ext + HIT_WIN_C);

  assign start_len     = (bus.chart_len > LEN_MAX) ? LEN_MAX : bus.chart_len;
  assign game_time_inc = (game_time_q == TIME_MAX) ? game_time_q : game_time_q + 1'b1;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      head_q      <= '0;
      game_time_q <= '0;
      hit_ok_q    <= 1'b0;
      miss_q      <= 1'b0;
      ret_type_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      head_q      <= head_d;
      game_time_q <= game_time_d;
      hit_ok_q    <= hit_ok_d;
      miss_q      <= miss_d;
      ret_type_q  <= ret_type_d;
    end
  end

  // Chart storage is deliberately left out of reset so a loaded chart survives it.
  always_ff @(posedge Clk) begin
    if (chart_we) begin
      chart_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    head_d      = head_q;
    game_time_d = game_time_q;
    hit_ok_d    = 1'b0;
    miss_d      = 1'b0;
    ret_type_d  = '0;
    chart_we    = 1'b0;

    if (bus.start) begin
      len_d       = start_len;
      head_d      = '0;
      game_time_d = '0;
      state_d     = (start_len == '0) ? S_DONE : S_RUN;
    end else begin
      case (state_q)
        S_IDLE: begin
          chart_we = bus.wr_en && Reset_n;
        end
        S_RUN: begin
          if (bus.hit && in_window) begin
            hit_ok_d = 1'b1;
          end else if (late) begin
            miss_d = 1'b1;
          end
          if (hit_ok_d || miss_d) begin
            head_d     = head_q + 1'b1;
            ret_type_d = head_type;
          end
          if (bus.frame_tick) begin
            game_time_d = game_time_inc;
          end
          if (head_d == len_q) begin
            state_d = S_DONE;
          end else if (bus.pause) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (!bus.pause) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          if (bus.frame_tick) begin
            game_time_d = game_time_inc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN, S_PAUSE: busy = 1'b1;
      S_DONE:         done = 1'b1;
      default:        ;
    endcase
  end

  assign bus.game_time = game_time_q;
  assign bus.head_addr = head_q;
  assign bus.win_data  = win_data;
  assign bus.win_valid = win_valid;
  assign bus.in_window = in_window;
  assign bus.hit_ok    = hit_ok_q;
  assign bus.miss      = miss_q;
  assign bus.ret_type  = ret_type_q;
  assign bus.busy      = busy;
  assign bus.done      = done;

endmodule

`default_nettype wire

// File: tb/tb_note_chart_window.sv
// tb_note_chart_window: directed and randomized bench against a behavioural lane model.
`timescale 1ns/1ps
`default_nettype none

module tb_note_chart_window;
  localparam int DEPTH   = 256;
  localparam int TIME_W  = 14;
  localparam int TYPE_W  = 2;
  localparam int WIN     = 4;
  localparam int HIT_WIN = 6;
  localparam int TMAX    = (1 << TIME_W) - 1;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  note_chart_if #(.DEPTH(DEPTH), .TIME_W(TIME_W), .TYPE_W(TYPE_W), .WIN(WIN)) bus ();

  note_chart_window #(
    .DEPTH(DEPTH), .TIME_W(TIME_W), .TYPE_W(TYPE_W), .WIN(WIN), .HIT_WIN(HIT_WIN)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

  mode_t m_mode = M_IDLE;
  int    m_gt = 0, m_head = 0, m_len = 0;
  int    m_chart [DEPTH];
  bit    e_hit = 0, e_miss = 0;
  int    e_rt = 0;

  int checks = 0, errors = 0;
  bit cmp_en = 0;

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Game rules applied once per clock edge to the inputs seen at that edge.
  task automatic model_step();
    bit hv;
    int ht;
    if (!Reset_n) begin
      m_mode = M_IDLE; m_gt = 0; m_head = 0; m_len = 0;
      e_hit = 0; e_miss = 0; e_rt = 0;
      return;
    end
    hv = m_head < m_len;
    ht = hv ? (m_chart[m_head] % (1 << TIME_W)) : 0;
    e_hit = 0; e_miss = 0; e_rt = 0;
    if (bus.start) begin
      m_len  = (int'(bus.chart_len) > DEPTH) ? DEPTH : int'(bus.chart_len);
      m_gt   = 0;
      m_head = 0;
      m_mode = (m_len == 0) ? M_DONE : M_RUN;
    end else begin
      case (m_mode)
        M_IDLE: if (bus.wr_en) m_chart[bus.wr_addr] = int'(bus.wr_data);
        M_RUN: begin
          if (hv && bus.hit && iabs(ht - m_gt) <= HIT_WIN) begin
            e_hit = 1; e_rt = m_chart[m_head] >> TIME_W; m_head++;
          end else if (hv && m_gt > ht + HIT_WIN) begin
            e_miss = 1; e_rt = m_chart[m_head] >> TIME_W; m_head++;
          end
          if (bus.frame_tick && m_gt < TMAX) m_gt++;
          if (m_head == m_len) m_mode = M_DONE;
          else if (bus.pause) m_mode = M_PAUSE;
        end
        M_PAUSE: if (!bus.pause) m_mode = M_RUN;
        M_DONE:  if (bus.frame_tick && m_gt < TMAX) m_gt++;
        default: ;
      endcase
    end
  endtask

  always @(negedge Clk) begin
    if (cmp_en) begin
      logic [63:0] ew;
      logic [3:0]  ev;
      bit          hv;
      ew = '0;
      ev = '0;
      for (int k = 0; k < WIN; k++) begin
        if (m_head + k < m_len) begin
          ev[k] = 1'b1;
          ew[k*16 +: 16] = 16'(m_chart[m_head + k]);
        end
      end
      hv = m_head < m_len;
      check("game_time", 64'(bus.game_time), 64'(m_gt));
      check("head_addr", 64'(bus.head_addr), 64'(m_head));
      check("win_valid", 64'(bus.win_valid), 64'(ev));
      check("win_data",  64'(bus.win_data),  ew);
      check("in_window", 64'(bus.in_window),
            64'(hv && iabs((m_chart[m_head] % (1 << TIME_W)) - m_gt) <= HIT_WIN));
      check("hit_ok",    64'(bus.hit_ok),   64'(e_hit));
      check("miss",      64'(bus.miss),     64'(e_miss));
      check("ret_type",  64'(bus.ret_type), 64'(e_rt));
      check("busy",      64'(bus.busy),     64'(m_mode == M_RUN || m_mode == M_PAUSE));
      check("done",      64'(bus.done),     64'(m_mode == M_DONE));
    end
  end

  task automatic cyc(input bit ft, input bit h, input bit p, input bit s);
    bus.frame_tick = ft; bus.hit = h; bus.pause = p; bus.start = s;
    @(posedge Clk);
    model_step();
    #2;
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en = 1'b1; bus.wr_addr = 8'(a); bus.wr_data = 16'(d);
    cyc(0, 0, 0, 0);
    bus.wr_en = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
  endtask

  task automatic do_start(input int len);
    bus.chart_len = 9'(len);
    cyc(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    cyc(0, 0, 0, 0);
    Reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t;
    bit p;
    bus.frame_tick = 0; bus.start = 0; bus.pause = 0; bus.hit = 0;
    bus.chart_len = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    for (int i = 0; i < DEPTH; i++) m_chart[i] = 0;

    Reset_n = 1'b0;
    cyc(0, 0, 0, 0);
    do_reset();
    cmp_en = 1;
    check("rst_game_time", 64'(bus.game_time), 64'd0);
    check("rst_busy_done", 64'({bus.busy, bus.done, bus.hit_ok, bus.miss}), 64'd0);
    check("rst_win_valid", 64'(bus.win_valid), 64'd0);

    // Full chart of time-0 notes, then hit down to head 254.
    for (int i = 0; i < DEPTH; i++) wr(i, int'($urandom_range(0, 3)) << TIME_W);
    do_start(256);
    for (int i = 0; i < 254; i++) cyc(0, 1, 0, 0);
    check("lit_head_254", 64'(bus.head_addr), 64'd254);
    check("lit_tail_valid", 64'(bus.win_valid), 64'b0011);
    check("lit_tail_zero", 64'(bus.win_data[63:32]), 64'd0);

    // Three-note chart: hit at 68.
    do_reset();
    wr(0, 71); wr(1, 125); wr(2, 178);
    do_start(3);
    ticks(68);
    check("lit_gt_68", 64'(bus.game_time), 64'd68);
    cyc(0, 1, 0, 0);
    check("lit_hit_ok", 64'(bus.hit_ok), 64'd1);
    check("lit_head_1", 64'(bus.head_addr), 64'd1);
    check("lit_wv_0011", 64'(bus.win_valid), 64'b0011);
    check("lit_slot0_125", 64'(bus.win_data[13:0]), 64'd125);

    // Restart from RUN and let every note time out.
    do_start(3);
    ticks(78); cyc(0, 0, 0, 0);
    check("lit_miss_78", 64'({bus.miss, bus.head_addr}), 64'({1'b1, 9'd1}));
    ticks(54); cyc(0, 0, 0, 0);
    check("lit_miss_132", 64'({bus.miss, bus.head_addr}), 64'({1'b1, 9'd2}));
    ticks(53); cyc(0, 0, 0, 0);
    check("lit_miss_185", 64'({bus.miss, bus.head_addr}), 64'({1'b1, 9'd3}));
    check("lit_done", 64'({bus.done, bus.busy}), 64'b10);

    // Early hit ignored, later hit accepted.
    do_start(3);
    ticks(60); cyc(0, 1, 0, 0);
    check("lit_early_hit", 64'({bus.hit_ok, bus.head_addr}), 64'd0);
    ticks(5); cyc(0, 1, 0, 0);
    check("lit_hit_65", 64'({bus.hit_ok, bus.head_addr}), 64'({1'b1, 9'd1}));

    // Pause freezes the clock and the miss.
    do_start(3);
    ticks(70);
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 100; i++) cyc(1, 0, 1, 0);
    check("lit_pause_gt", 64'({bus.game_time, bus.head_addr, bus.miss}), 64'({14'd70, 9'd0, 1'b0}));
    cyc(0, 0, 0, 0);
    ticks(8); cyc(0, 0, 0, 0);
    check("lit_pause_miss", 64'({bus.miss, bus.head_addr}), 64'({1'b1, 9'd1}));

    // Saturating game clock near the top of the time range.
    do_reset();
    wr(0, 16380);
    do_start(1);
    ticks(TMAX + 7);
    check("lit_sat_gt", 64'(bus.game_time), 64'(TMAX));
    check("lit_sat_nomiss", 64'({bus.miss, bus.head_addr, bus.in_window}), 64'({1'b0, 9'd0, 1'b1}));
    Reset_n = 1'b0;
    cyc(1, 0, 0, 0);
    Reset_n = 1'b1;
    check("lit_midrst", 64'({bus.busy, bus.done, bus.game_time, bus.win_valid}), 64'd0);
    do_start(1);
    check("lit_restart", 64'({bus.busy, bus.game_time}), 64'({1'b1, 14'd0}));

    // Randomized play against the model.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = $urandom_range(1, 24);
      t = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) begin
        wr(i, (int'($urandom_range(0, 3)) << TIME_W) | t);
        t += $urandom_range(0, 25);
      end
      do_start((r == 5) ? 300 : n);
      p = 0;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 39) == 0) p = !p;
        bus.wr_en   = ($urandom_range(0, 7) == 0);
        bus.wr_addr = 8'($urandom);
        bus.wr_data = 16'($urandom);
        bus.chart_len = 9'($urandom_range(0, 30));
        Reset_n = ($urandom_range(0, 699) != 0);
        cyc($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, p,
            $urandom_range(0, 299) == 0);
      end
      bus.wr_en = 1'b0;
      Reset_n = 1'b1;
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
